mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Memory-side responder for the pipeline's fetch and load/store request lines. It produces the ihit/dhit pulses that the hazard control unit uses to gate the PC and pipeline-register enables.
- Arbitrates instruction-fetch and data requests onto a single-port RAM, holds each granted access until the RAM completes, and returns a one-cycle registered hit with its data.
- Sits between the datapath request logic and the RAM model, replacing direct combinational RAM wiring.

Parameters:
- TIMEOUT, 255, cycles a granted access may wait for ramdone before the arbiter aborts it and raises merr.
- CNTW, 8, width of the timeout counter; must satisfy 2^CNTW > TIMEOUT.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RST  in  1  synchronous reset, active-high.
- iREN  in  1  instruction fetch request; held until ihit.
- iaddr  in  32  fetch word address.
- ihit  out  1  one-cycle pulse; iload is valid in this cycle.
- iload  out  32  fetched instruction.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; dREN and dWEN together is illegal.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dhit  out  1  one-cycle pulse; dload is valid in this cycle.
- dload  out  32  read data; holds its last value after a write.
- ramREN  out  1  RAM read strobe, held for the whole access.
- ramWEN  out  1  RAM write strobe, held for the whole access.
- ramaddr  out  32  RAM address, latched at grant.
- ramstore  out  32  RAM write data, latched at grant.
- ramload  in  32  RAM read data, valid when ramdone=1.
- ramdone  in  1  RAM completion pulse.
- merr  out  1  sticky timeout error flag.

Behaviour:
- Reset (synchronous, active-high; RST is checked first, so reset wins over any other event and aborts an in-flight access):
  - state=IDLE.
  - ihit=dhit=0, iload=dload=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0.
  - merr=0, counter=0.
- States: IDLE, IACC, DACC, RESP.
- IDLE:
  - If dREN|dWEN: go to DACC. Data has priority, because the pipeline is already stalled on dhit.
  - Else if iREN: go to IACC.
  - At grant, latch the address into ramaddr, latch dstore into ramstore, and assert ramREN or ramWEN from the next cycle. The counter is cleared.
- IACC/DACC:
  - Strobes are held and the counter increments each cycle.
  - On ramdone: register ramload into iload/dload (writes do not update dload), drop the strobes, and go to RESP with the matching hit asserted.
  - If the counter reaches TIMEOUT without ramdone: set merr, drop the strobes, and go to IDLE with no hit.
- Stale-fetch discard: in IACC, if ramdone arrives and iaddr != ramaddr (the PC changed after a branch or jump flush) or iREN=0, no ihit is issued; go to IDLE.
  - A data access is never discarded.
- RESP: hits are deasserted; return to IDLE. This is one guaranteed bubble, so a request still held in the hit cycle is never double-served.
- Latency: minimum grant-to-hit is 2 cycles plus the RAM latency.
  - With ramdone in the first access cycle, the sequence is request in IDLE (cycle 0), access (cycle 1), hit (cycle 2).
- Simultaneous events:
  - iREN and dREN both high in IDLE: data wins; the fetch is served after RESP.
  - ramdone and timeout in the same cycle: ramdone wins.
- ihit and dhit are never high in the same cycle.
- merr is cleared only by RST.

Decomposition:
- The state enum (IDLE, IACC, DACC, RESP) goes in a new mem_arbiter_types_pkg alongside the existing types packages; word_t comes from cpu_types_pkg.
- Sub-module mem_timeout_counter (CNTW-bit up-counter with clear, enable and terminal-count output): instantiated once.
- Interface file mem_arbiter_if.vh with modport ma for the arbiter and modports dp and ram for its peers.

Test Plan:
- Single fetch: iREN=1, iaddr=0x0000_0040, RAM returns 0x8C01_0004 with ramdone at access cycle 3 -> ramREN=1 with ramaddr=0x40 for 3 cycles, ihit pulses 1 cycle later with iload=0x8C01_0004, then one idle cycle.
- Contention: iREN=1 and dREN=1 in the same cycle (daddr=0x100) -> the data access is granted first and dhit fires. The fetch is granted after RESP, and ihit fires afterwards, never together with dhit.
- Store: dWEN=1, daddr=0x200, dstore=0xDEAD_BEEF -> ramWEN=1 with ramaddr=0x200 and ramstore=0xDEAD_BEEF held until ramdone, then dhit pulses; dload is unchanged.
- Stale fetch: iaddr changes from 0x40 to 0x80 mid-IACC -> ramdone produces no ihit; the next grant is for 0x80 and that ihit returns the 0x80 data.
- Timeout: TIMEOUT=4, ramdone never asserted -> strobes drop after 4 access cycles, merr=1 and stays 1, no hit; a later request is served normally.
- Reset mid-access: RST=1 during DACC -> the next cycle has all outputs 0 and state IDLE; a late ramdone produces no dhit.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types used by the datapath and memory-side blocks.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage : cpu_types_pkg

// File: rtl/mem_arbiter_types_pkg.sv
// State encoding for the instruction/data memory arbiter.
package mem_arbiter_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        RESP = 2'd3
    } arb_state_t;

endpackage : mem_arbiter_types_pkg

// File: rtl/mem_timeout_counter.sv
// Up-counter with clear and enable; o_tc flags the last permitted enabled cycle.
module mem_timeout_counter #(
    parameter int CNTW     = 8,
    parameter int TERMINAL = 254
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNTW-1:0] TC_VAL = CNTW'(TERMINAL);

    logic [CNTW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_srst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Asserted in the enabled cycle whose increment would reach the limit.
    assign o_tc = i_en && (r_count == TC_VAL);

endmodule : mem_timeout_counter

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto a single-port RAM and returns
// registered one-cycle ihit/dhit pulses; aborts stuck accesses with sticky merr.
module mem_arbiter
    import cpu_types_pkg::*;
    import mem_arbiter_types_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 8
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  iREN,
    input  word_t iaddr,
    output logic  ihit,
    output word_t iload,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t daddr,
    input  word_t dstore,
    output logic  dhit,
    output word_t dload,
    output logic  ramREN,
    output logic  ramWEN,
    output word_t ramaddr,
    output word_t ramstore,
    input  word_t ramload,
    input  logic  ramdone,
    output logic  merr
);

    arb_state_t r_state, w_state_next;

    logic  r_ihit, w_ihit_next;
    logic  r_dhit, w_dhit_next;
    word_t r_iload, w_iload_next;
    word_t r_dload, w_dload_next;
    logic  r_ren, w_ren_next;
    logic  r_wen, w_wen_next;
    word_t r_addr, w_addr_next;
    word_t r_store, w_store_next;
    logic  r_merr, w_merr_next;

    logic  w_cnt_clr;
    logic  w_cnt_en;
    logic  w_timeout;

    mem_timeout_counter #(
        .CNTW     (CNTW),
        .TERMINAL (TIMEOUT - 1)
    ) u_timeout (
        .i_clk  (CLK),
        .i_srst (RST),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_tc   (w_timeout)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ihit_next  = 1'b0;
        w_dhit_next  = 1'b0;
        w_iload_next = r_iload;
        w_dload_next = r_dload;
        w_ren_next   = r_ren;
        w_wen_next   = r_wen;
        w_addr_next  = r_addr;
        w_store_next = r_store;
        w_merr_next  = r_merr;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;

        case (r_state)
            IDLE: begin
                // Data first: the pipeline is already stalled waiting on dhit.
                if (dREN || dWEN) begin
                    w_state_next = DACC;
                    w_addr_next  = daddr;
                    w_store_next = dstore;
                    w_ren_next   = dREN;
                    w_wen_next   = dWEN;
                    w_cnt_clr    = 1'b1;
                end else if (iREN) begin
                    w_state_next = IACC;
                    w_addr_next  = iaddr;
                    w_store_next = dstore;
                    w_ren_next   = 1'b1;
                    w_wen_next   = 1'b0;
                    w_cnt_clr    = 1'b1;
                end
            end

            IACC: begin
                w_cnt_en = 1'b1;
                if (ramdone) begin
                    w_ren_next = 1'b0;
                    w_wen_next = 1'b0;
                    // A flushed or redirected fetch completes silently.
                    if (iREN && (iaddr == r_addr)) begin
                        w_iload_next = ramload;
                        w_ihit_next  = 1'b1;
                        w_state_next = RESP;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else if (w_timeout) begin
                    w_merr_next  = 1'b1;
                    w_ren_next   = 1'b0;
                    w_wen_next   = 1'b0;
                    w_state_next = IDLE;
                end
            end

            DACC: begin
                w_cnt_en = 1'b1;
                if (ramdone) begin
                    if (r_ren) begin
                        w_dload_next = ramload;
                    end
                    w_dhit_next  = 1'b1;
                    w_ren_next   = 1'b0;
                    w_wen_next   = 1'b0;
                    w_state_next = RESP;
                end else if (w_timeout) begin
                    w_merr_next  = 1'b1;
                    w_ren_next   = 1'b0;
                    w_wen_next   = 1'b0;
                    w_state_next = IDLE;
                end
            end

            RESP: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ihit  <= 1'b0;
            r_dhit  <= 1'b0;
            r_iload <= '0;
            r_dload <= '0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_store <= '0;
            r_merr  <= 1'b0;
        end else begin
            r_ihit  <= w_ihit_next;
            r_dhit  <= w_dhit_next;
            r_iload <= w_iload_next;
            r_dload <= w_dload_next;
            r_ren   <= w_ren_next;
            r_wen   <= w_wen_next;
            r_addr  <= w_addr_next;
            r_store <= w_store_next;
            r_merr  <= w_merr_next;
        end
    end

    assign ihit     = r_ihit;
    assign dhit     = r_dhit;
    assign iload    = r_iload;
    assign dload    = r_dload;
    assign ramREN   = r_ren;
    assign ramWEN   = r_wen;
    assign ramaddr  = r_addr;
    assign ramstore = r_store;
    assign merr     = r_merr;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, store, stale fetch,
// timeout and reset-abort scenarios with hand-computed expectations.
module tb_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramdone;
    logic        merr;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .TIMEOUT (4),
        .CNTW    (3)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .ihit     (ihit),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dhit     (dhit),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramdone  (ramdone),
        .merr     (merr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling registered outputs.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramdone = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_ihit", ihit, 0);
        chk("rst_dhit", dhit, 0);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_merr", merr, 0);
        $display("txn reset done");

        // Single fetch, ramdone in access cycle 3
        RST = 1'b0; iREN = 1'b1; iaddr = 32'h0000_0040;
        step();
        chk("f1_ren_c1", ramREN, 1);
        chk("f1_addr", ramaddr, 32'h40);
        step();
        chk("f1_ren_c2", ramREN, 1);
        chk("f1_ihit_c2", ihit, 0);
        step();
        chk("f1_ren_c3", ramREN, 1);
        ramdone = 1'b1; ramload = 32'h8C01_0004;
        step();
        ramdone = 1'b0;
        chk("f1_ihit", ihit, 1);
        chk("f1_iload", iload, 32'h8C01_0004);
        chk("f1_ren_drop", ramREN, 0);
        chk("f1_dhit", dhit, 0);
        step();
        iREN = 1'b0;
        chk("f1_ihit_pulse", ihit, 0);
        chk("f1_idle_ren", ramREN, 0);
        step();
        chk("f1_idle2_ren", ramREN, 0);
        $display("txn fetch addr=%h iload=%h", 32'h40, iload);

        // Contention: data wins, fetch follows after RESP
        iREN = 1'b1; iaddr = 32'h0000_0044; dREN = 1'b1; daddr = 32'h0000_0100;
        step();
        chk("ct_d_addr", ramaddr, 32'h100);
        chk("ct_d_ren", ramREN, 1);
        ramdone = 1'b1; ramload = 32'h1111_2222;
        step();
        ramdone = 1'b0; dREN = 1'b0;
        chk("ct_dhit", dhit, 1);
        chk("ct_ihit_in_dhit", ihit, 0);
        chk("ct_dload", dload, 32'h1111_2222);
        step();
        chk("ct_resp_dhit", dhit, 0);
        chk("ct_resp_ihit", ihit, 0);
        chk("ct_resp_ren", ramREN, 0);
        step();
        chk("ct_i_addr", ramaddr, 32'h44);
        chk("ct_i_ren", ramREN, 1);
        ramdone = 1'b1; ramload = 32'h3333_4444;
        step();
        ramdone = 1'b0;
        chk("ct_ihit", ihit, 1);
        chk("ct_dhit_in_ihit", dhit, 0);
        chk("ct_iload", iload, 32'h3333_4444);
        step();
        iREN = 1'b0;
        $display("txn contention dload=%h iload=%h", dload, iload);

        // Store: dload must not change
        dWEN = 1'b1; daddr = 32'h0000_0200; dstore = 32'hDEAD_BEEF;
        step();
        chk("st_wen", ramWEN, 1);
        chk("st_ren", ramREN, 0);
        chk("st_addr", ramaddr, 32'h200);
        chk("st_data", ramstore, 32'hDEAD_BEEF);
        step();
        chk("st_wen_hold", ramWEN, 1);
        ramdone = 1'b1; ramload = 32'h5555_5555;
        step();
        ramdone = 1'b0; dWEN = 1'b0;
        chk("st_dhit", dhit, 1);
        chk("st_dload_kept", dload, 32'h1111_2222);
        chk("st_wen_drop", ramWEN, 0);
        step();
        $display("txn store addr=%h data=%h", 32'h200, 32'hDEAD_BEEF);

        // Stale fetch: PC moves mid-access
        iREN = 1'b1; iaddr = 32'h0000_0040;
        step();
        chk("sf_addr1", ramaddr, 32'h40);
        iaddr = 32'h0000_0080;
        step();
        ramdone = 1'b1; ramload = 32'h6666_6666;
        step();
        ramdone = 1'b0;
        chk("sf_no_ihit", ihit, 0);
        chk("sf_ren_drop", ramREN, 0);
        step();
        chk("sf_addr2", ramaddr, 32'h80);
        chk("sf_ren2", ramREN, 1);
        ramdone = 1'b1; ramload = 32'h7777_8888;
        step();
        ramdone = 1'b0;
        chk("sf_ihit", ihit, 1);
        chk("sf_iload", iload, 32'h7777_8888);
        step();
        iREN = 1'b0;
        $display("txn stale_fetch reissue addr=%h iload=%h", 32'h80, iload);

        // Timeout after 4 access cycles
        dREN = 1'b1; daddr = 32'h0000_0300;
        step();
        chk("to_ren_c1", ramREN, 1);
        chk("to_merr_c1", merr, 0);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk($sformatf("to_ren_c%0d", i), ramREN, 1);
        end
        step();
        dREN = 1'b0;
        chk("to_ren_drop", ramREN, 0);
        chk("to_merr_set", merr, 1);
        chk("to_no_dhit", dhit, 0);
        step();
        chk("to_merr_sticky", merr, 1);
        iREN = 1'b1; iaddr = 32'h0000_0090;
        step();
        chk("to_next_addr", ramaddr, 32'h90);
        ramdone = 1'b1; ramload = 32'h9999_0000;
        step();
        ramdone = 1'b0;
        chk("to_next_ihit", ihit, 1);
        chk("to_next_iload", iload, 32'h9999_0000);
        chk("to_merr_still", merr, 1);
        step();
        iREN = 1'b0;
        $display("txn timeout merr=%0b", merr);

        // Reset during a data access, then a late ramdone
        dREN = 1'b1; daddr = 32'h0000_0400; dstore = 32'h0000_1234;
        step();
        chk("rm_ren", ramREN, 1);
        RST = 1'b1;
        step();
        chk("rm_ren0", ramREN, 0);
        chk("rm_addr0", ramaddr, 0);
        chk("rm_store0", ramstore, 0);
        chk("rm_merr0", merr, 0);
        chk("rm_iload0", iload, 0);
        chk("rm_dload0", dload, 0);
        RST = 1'b0; dREN = 1'b0; ramdone = 1'b1; ramload = 32'hBAD0_BAD0;
        step();
        ramdone = 1'b0;
        chk("rm_late_dhit", dhit, 0);
        chk("rm_late_ren", ramREN, 0);
        chk("rm_late_dload", dload, 0);
        $display("txn reset_mid_access dhit=%0b", dhit);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter
